// File: rtl/accum_pkg.sv
// Shared helpers for the valid/ready group accumulator: width derivation
// functions and reset constants.
package accum_pkg;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  function automatic int out_w(input int data_w, input int n);
    return data_w + clog2(n);
  endfunction

  function automatic int cnt_w(input int n);
    return clog2(n + 1);
  endfunction

  localparam logic RST_OUT_VALID = 1'b0;

endpackage

// File: rtl/valid_ready_accum_if.sv
// Handshake bundle for valid_ready_accum: input beat stream and output sum stream.
// Handshake: a beat/sum transfers on a rising edge where valid & ready are both 1;
// the producer holds data stable while valid is high and ready is low.
interface valid_ready_accum_if
  import accum_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int GROUP_N = 4
) ();
    localparam int OUT_W = out_w(DATA_W, GROUP_N);
    localparam int CNT_W = cnt_w(GROUP_N);

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [OUT_W-1:0]  out_data;
    logic [CNT_W-1:0]  out_count;
    logic              out_valid;
    logic              out_ready;

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_count, out_valid
    );

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_count, out_valid
    );
endinterface

// File: rtl/accum_beat_cnt.sv
// Beat counter for one group: counts accepted beats 0..GROUP_N-1 and flags
// the first beat of a group and the beat that closes it.
module accum_beat_cnt
  import accum_pkg::*;
#(
    parameter int GROUP_N = 4,
    parameter int CNT_W   = cnt_w(GROUP_N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             last_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             first_o,
    output logic             close_o
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign first_o = (cnt_q == '0);
    assign close_o = inc_i & (last_i | (cnt_q == CNT_W'(GROUP_N - 1)));
    assign cnt_o   = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (close_o) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/valid_ready_accum.sv
// Serial group accumulator: sums GROUP_N beats (or fewer, closed by in_last)
// into one full-precision sum. Build with VALID_READY_ACCUM_SIGNED_EN for
// two's-complement beats; otherwise beats are unsigned.
module valid_ready_accum
  import accum_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int GROUP_N = 4
) (
    input logic                clk,
    input logic                rst_n,
    valid_ready_accum_if.slave bus
);
    localparam int OUT_W = out_w(DATA_W, GROUP_N);
    localparam int CNT_W = cnt_w(GROUP_N);

    logic [OUT_W-1:0] acc_q, acc_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_valid_q, out_valid_d;

    logic             in_ready;
    logic             in_fire;
    logic             out_fire;
    logic [CNT_W-1:0] cnt;
    logic             first;
    logic             close;
    logic [OUT_W-1:0] addend;
    logic [OUT_W-1:0] sum;

    // A pending sum stalls input only when downstream is not taking it this cycle.
    assign in_ready = ~out_valid_q | bus.out_ready;
    assign in_fire  = bus.in_valid & in_ready;
    assign out_fire = out_valid_q & bus.out_ready;

    accum_beat_cnt #(
        .GROUP_N (GROUP_N),
        .CNT_W   (CNT_W)
    ) u_beat_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (in_fire),
        .last_i  (bus.in_last),
        .cnt_o   (cnt),
        .first_o (first),
        .close_o (close)
    );

`ifdef VALID_READY_ACCUM_SIGNED_EN
    assign addend = {{(OUT_W - DATA_W){bus.in_data[DATA_W-1]}}, bus.in_data};
`else
    assign addend = {{(OUT_W - DATA_W){1'b0}}, bus.in_data};
`endif

    // The first beat of a group overwrites the accumulator, so no clear cycle is needed.
    assign sum = first ? addend : (acc_q + addend);

    always_comb begin
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_valid_d = out_valid_q;
        if (in_fire) begin
            acc_d = sum;
        end
        if (close) begin
            out_valid_d = 1'b1;
            out_data_d  = sum;
            out_count_d = cnt + CNT_W'(1);
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_valid_q <= RST_OUT_VALID;
        end else begin
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_count = out_count_q;
    assign bus.out_valid = out_valid_q;
endmodule
